// File: rtl/input_mems.sv
// -----------------------------------------------------------------------------
// input_mems
//
// Purpose:
//   Loads a kernel matrix W (up to MAXK x MAXK words) and an input matrix X
//   (R x C words) from an AXI-Stream-like port into two single-port
//   synchronous memories. Once both are complete the block holds them
//   read-only for a consumer until compute_finished releases them.
//
//   A transfer whose first word has new_W=1 carries a fresh kernel: K words
//   squared go to W, then R*C words go to X. A transfer with new_W=0 carries
//   only X and reuses the previously loaded W and K.
//
// Ports:
//   clk              rising-edge clock
//   reset            asynchronous, active-high reset (control state only)
//   AXIS_TDATA       incoming data word
//   AXIS_TVALID      producer has a word
//   AXIS_TUSER       bit 0 = new_W, bits [K_BITS:1] = K (first word only)
//   AXIS_TREADY      block accepts a word this cycle
//   inputs_loaded    X and W complete and readable
//   compute_finished consumer done, releases the buffers (DONE only)
//   K                current kernel dimension
//   X_read_addr      X read address, row-major r*C+c
//   X_data           X read data, one cycle after the address
//   W_read_addr      W read address, row-major i*K+j
//   W_data           W read data, one cycle after the address
// -----------------------------------------------------------------------------
module input_mems #(
  parameter int INW    = 12,
  parameter int R      = 9,
  parameter int C      = 8,
  parameter int MAXK   = 4,
  parameter int K_BITS = $clog2(MAXK + 1),
  parameter int XA_W   = $clog2(R * C),
  parameter int WA_W   = $clog2(MAXK * MAXK)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [INW-1:0]    AXIS_TDATA,
  input  logic              AXIS_TVALID,
  input  logic [K_BITS:0]   AXIS_TUSER,
  output logic              AXIS_TREADY,
  output logic              inputs_loaded,
  input  logic              compute_finished,
  output logic [K_BITS-1:0] K,
  input  logic [XA_W-1:0]   X_read_addr,
  output logic [INW-1:0]    X_data,
  input  logic [WA_W-1:0]   W_read_addr,
  output logic [INW-1:0]    W_data
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD_W = 2'd1;
  localparam logic [1:0] S_LOAD_X = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  // Wide enough to hold K*K for any K the TUSER field can express.
  localparam int CW = 2 * K_BITS + WA_W;
  localparam logic [XA_W-1:0] X_LAST = XA_W'(R * C - 1);
  localparam logic [CW-1:0]   W_SIZE = CW'(MAXK * MAXK);

  logic [1:0]        state_q, state_d;
  logic [WA_W-1:0]   wcnt_q, wcnt_d;
  logic [XA_W-1:0]   xcnt_q, xcnt_d;
  logic [K_BITS-1:0] k_q, k_d;

  logic              xfer;
  logic              new_w;
  logic [K_BITS-1:0] k_in;
  logic [CW-1:0]     wnext_ext;
  logic [CW-1:0]     kk_ext;
  logic              w_last;
  logic              w_we;
  logic              x_we;
  logic [WA_W-1:0]   w_addr;
  logic [XA_W-1:0]   x_addr;

  logic [INW-1:0]    x_mem [0:R*C-1];
  logic [INW-1:0]    w_mem [0:MAXK*MAXK-1];
  logic [INW-1:0]    x_rdata_q;
  logic [INW-1:0]    w_rdata_q;

  assign AXIS_TREADY   = (state_q != S_DONE);
  assign inputs_loaded = (state_q == S_DONE);
  assign K             = k_q;

  assign xfer  = AXIS_TVALID && AXIS_TREADY;
  assign new_w = AXIS_TUSER[0];
  assign k_in  = AXIS_TUSER[K_BITS:1];

  // The last W word is the one at K*K-1. A K larger than the memory can hold
  // is cut off at the end of W so writes never leave the array.
  assign wnext_ext = CW'(wcnt_q) + CW'(1);
  assign kk_ext    = CW'(k_q) * CW'(k_q);
  assign w_last    = (wnext_ext == kk_ext) || (wnext_ext >= W_SIZE);

  assign w_we = xfer && (((state_q == S_IDLE) && new_w) || (state_q == S_LOAD_W));
  assign x_we = xfer && (((state_q == S_IDLE) && !new_w) || (state_q == S_LOAD_X));

  // Counters sit at 0 in IDLE, so the first word lands at address 0.
  assign w_addr = (state_q == S_DONE) ? W_read_addr : wcnt_q;
  assign x_addr = (state_q == S_DONE) ? X_read_addr : xcnt_q;

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    xcnt_d  = xcnt_q;
    k_d     = k_q;
    unique case (state_q)
      S_IDLE: begin
        if (xfer) begin
          if (new_w) begin
            k_d    = k_in;
            wcnt_d = WA_W'(1);
            xcnt_d = '0;
            // A 1x1 (or degenerate 0) kernel is complete after this word.
            state_d = (k_in <= K_BITS'(1)) ? S_LOAD_X : S_LOAD_W;
          end else begin
            xcnt_d  = XA_W'(1);
            state_d = (X_LAST == '0) ? S_DONE : S_LOAD_X;
          end
        end
      end
      S_LOAD_W: begin
        if (xfer) begin
          if (w_last) begin
            xcnt_d  = '0;
            state_d = S_LOAD_X;
          end else begin
            wcnt_d = wcnt_q + WA_W'(1);
          end
        end
      end
      S_LOAD_X: begin
        if (xfer) begin
          if (xcnt_q == X_LAST) begin
            state_d = S_DONE;
          end else begin
            xcnt_d = xcnt_q + XA_W'(1);
          end
        end
      end
      S_DONE: begin
        if (compute_finished) begin
          wcnt_d  = '0;
          xcnt_d  = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
      xcnt_q  <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      xcnt_q  <= xcnt_d;
      k_q     <= k_d;
    end
  end

  // Single-port memories with registered read; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_we) begin
      w_mem[w_addr] <= AXIS_TDATA;
    end
    w_rdata_q <= w_mem[w_addr];
  end

  always_ff @(posedge clk) begin
    if (x_we) begin
      x_mem[x_addr] <= AXIS_TDATA;
    end
    x_rdata_q <= x_mem[x_addr];
  end

  assign X_data = x_rdata_q;
  assign W_data = w_rdata_q;

endmodule

// File: tb/tb_input_mems.sv
module tb_input_mems;

  localparam int INW    = 12;
  localparam int R      = 3;
  localparam int C      = 3;
  localparam int MAXK   = 4;
  localparam int K_BITS = $clog2(MAXK + 1);
  localparam int XA_W   = $clog2(R * C);
  localparam int WA_W   = $clog2(MAXK * MAXK);

  // TUSER encodings {K, new_W}
  localparam logic [K_BITS:0] U_K2_NEW  = {3'd2, 1'b1};
  localparam logic [K_BITS:0] U_K3_OLD  = {3'd3, 1'b0};
  localparam logic [K_BITS:0] U_K1_NEW  = {3'd1, 1'b1};
  localparam logic [K_BITS:0] U_JUNK    = {3'd4, 1'b1};

  logic              clk = 1'b0;
  logic              reset;
  logic [INW-1:0]    AXIS_TDATA;
  logic              AXIS_TVALID;
  logic [K_BITS:0]   AXIS_TUSER;
  logic              AXIS_TREADY;
  logic              inputs_loaded;
  logic              compute_finished;
  logic [K_BITS-1:0] K;
  logic [XA_W-1:0]   X_read_addr;
  logic [INW-1:0]    X_data;
  logic [WA_W-1:0]   W_read_addr;
  logic [INW-1:0]    W_data;

  int checks   = 0;
  int failures = 0;

  input_mems #(.INW(INW), .R(R), .C(C), .MAXK(MAXK)) dut (
    .clk              (clk),
    .reset            (reset),
    .AXIS_TDATA       (AXIS_TDATA),
    .AXIS_TVALID      (AXIS_TVALID),
    .AXIS_TUSER       (AXIS_TUSER),
    .AXIS_TREADY      (AXIS_TREADY),
    .inputs_loaded    (inputs_loaded),
    .compute_finished (compute_finished),
    .K                (K),
    .X_read_addr      (X_read_addr),
    .X_data           (X_data),
    .W_read_addr      (W_read_addr),
    .W_data           (W_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One word with TVALID high for one edge; optionally followed by an idle
  // cycle carrying garbage data.
  task automatic word(input logic [INW-1:0] d, input logic [K_BITS:0] u, input bit gap);
    AXIS_TVALID = 1'b1;
    AXIS_TDATA  = d;
    AXIS_TUSER  = u;
    tick();
    AXIS_TVALID = 1'b0;
    if (gap) begin
      AXIS_TDATA = '1;
      AXIS_TUSER = U_JUNK;
      tick();
    end
  endtask

  // n consecutive words first..first+n-1; only the first carries user.
  task automatic load(input int n, input int first, input logic [K_BITS:0] u, input bit gap);
    for (int i = 0; i < n; i++) begin
      word(INW'(first + i), (i == 0) ? u : U_JUNK, gap);
    end
  endtask

  task automatic rd_x(input int a, input int exp, input string tag);
    X_read_addr = XA_W'(a);
    tick();
    chk(tag, 32'(X_data), exp);
  endtask

  task automatic rd_w(input int a, input int exp, input string tag);
    W_read_addr = WA_W'(a);
    tick();
    chk(tag, 32'(W_data), exp);
  endtask

  task automatic release_buffers();
    compute_finished = 1'b1;
    tick();
    compute_finished = 1'b0;
  endtask

  initial begin
    reset            = 1'b1;
    AXIS_TDATA       = '0;
    AXIS_TVALID      = 1'b0;
    AXIS_TUSER       = '0;
    compute_finished = 1'b0;
    X_read_addr      = '0;
    W_read_addr      = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("rst_tready", 32'(AXIS_TREADY), 1);
    chk("rst_loaded", 32'(inputs_loaded), 0);
    chk("rst_k", 32'(K), 0);

    // Kernel K=2 then X, streaming: W=1..4, X=5..13
    load(12, 1, U_K2_NEW, 1'b0);
    chk("s1_loaded_before_last", 32'(inputs_loaded), 0);
    chk("s1_tready_before_last", 32'(AXIS_TREADY), 1);
    word(12'd13, U_JUNK, 1'b0);
    chk("s1_loaded", 32'(inputs_loaded), 1);
    chk("s1_tready_done", 32'(AXIS_TREADY), 0);
    chk("s1_k", 32'(K), 2);
    for (int i = 0; i < 9; i++) rd_x(i, 5 + i, "s1_x");
    for (int i = 0; i < 4; i++) rd_w(i, 1 + i, "s1_w");
    rd_x(4, 9, "s1_x_addr4");
    // Words offered while DONE must not be taken
    word(12'd77, U_K2_NEW, 1'b0);
    chk("s1_done_holds", 32'(inputs_loaded), 1);
    rd_x(0, 5, "s1_x0_after_offer");

    // Release, then X-only batch 20..28; compute_finished pulsed mid-load
    release_buffers();
    chk("s2_idle_loaded", 32'(inputs_loaded), 0);
    chk("s2_idle_tready", 32'(AXIS_TREADY), 1);
    load(5, 20, U_K3_OLD, 1'b0);
    compute_finished = 1'b1;
    word(12'd25, U_JUNK, 1'b0);
    compute_finished = 1'b0;
    chk("s2_cf_ignored", 32'(inputs_loaded), 0);
    load(2, 26, U_JUNK, 1'b0);
    chk("s2_loaded_before_last", 32'(inputs_loaded), 0);
    word(12'd28, U_JUNK, 1'b0);
    chk("s2_loaded", 32'(inputs_loaded), 1);
    chk("s2_k_kept", 32'(K), 2);
    for (int i = 0; i < 9; i++) rd_x(i, 20 + i, "s2_x");
    for (int i = 0; i < 4; i++) rd_w(i, 1 + i, "s2_w");

    // Same 13-word load with TVALID alternating 1/0: 13 valid/idle pairs.
    // The idle cycles carry all-ones data that must not be written.
    release_buffers();
    load(12, 1, U_K2_NEW, 1'b1);
    chk("s3_loaded_before_last", 32'(inputs_loaded), 0);
    word(12'd13, U_JUNK, 1'b1);
    chk("s3_loaded", 32'(inputs_loaded), 1);
    chk("s3_tready", 32'(AXIS_TREADY), 0);
    chk("s3_k", 32'(K), 2);
    for (int i = 0; i < 9; i++) rd_x(i, 5 + i, "s3_x");
    for (int i = 0; i < 4; i++) rd_w(i, 1 + i, "s3_w");

    // Abort a load with reset after word 6, then a fresh K=1 batch
    release_buffers();
    load(6, 1, U_K2_NEW, 1'b0);
    reset = 1'b1;
    #1;
    chk("s4_rst_loaded", 32'(inputs_loaded), 0);
    chk("s4_rst_k", 32'(K), 0);
    chk("s4_rst_tready", 32'(AXIS_TREADY), 1);
    tick();
    reset = 1'b0;
    tick();
    load(9, 50, U_K1_NEW, 1'b0);
    chk("s4_loaded_before_last", 32'(inputs_loaded), 0);
    word(12'd59, U_JUNK, 1'b0);
    chk("s4_loaded", 32'(inputs_loaded), 1);
    chk("s4_k", 32'(K), 1);
    rd_w(0, 50, "s4_w0");
    for (int i = 0; i < 9; i++) rd_x(i, 51 + i, "s4_x");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Backstop so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/input_mems.md
INPUT_MEMS -- requirements
Module: input_mems

Interface
REQ-001 Parameter INW, 12, data word width in bits.
REQ-002 Parameter R, 9, input-matrix rows.
REQ-003 Parameter C, 8, input-matrix columns.
REQ-004 Parameter MAXK, 4, maximum kernel dimension; K_BITS = $clog2(MAXK+1).
REQ-005 clk  input  1  the only clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 AXIS_TDATA  input  INW  incoming data word.
REQ-008 AXIS_TVALID  input  1  producer has a valid word.
REQ-009 AXIS_TUSER  input  K_BITS+1  bit 0 = new_W; bits [K_BITS:1] = K; sampled only on the first word of a transfer.
REQ-010 AXIS_TREADY  output  1  block accepts a word this cycle.
REQ-011 inputs_loaded  output  1  X and W are complete and readable.
REQ-012 compute_finished  input  1  consumer done; releases the buffers.
REQ-013 K  output  K_BITS  current kernel dimension.
REQ-014 X_read_addr  input  $clog2(R*C)  X read address, row-major (r*C+c).
REQ-015 X_data  output  INW  X read data.
REQ-016 W_read_addr  input  $clog2(MAXK*MAXK)  W read address, row-major (i*K+j).
REQ-017 W_data  output  INW  W read data.

Function
REQ-018 The block SHALL contain two single-port synchronous memories: X (R*C words) and W (MAXK*MAXK words), each with 1-cycle read latency and write-on-wr_en.
REQ-019 FSM states SHALL be IDLE, LOAD_W, LOAD_X and DONE.
REQ-020 A word SHALL transfer only in a cycle where AXIS_TVALID and AXIS_TREADY are both 1; TVALID low stalls the counters with no write.
REQ-021 AXIS_TREADY SHALL be 1 in IDLE, LOAD_W and LOAD_X, and 0 in DONE.
REQ-022 IDLE, on transfer with new_W=1: latch K from TUSER; write the word to W[0]; go to LOAD_X if K==1, else to LOAD_W.
REQ-023 IDLE, on transfer with new_W=0: keep K; write the word to X[0]; go to LOAD_X.
REQ-024 LOAD_W SHALL write each transfer to W[wcnt], wcnt incrementing; after the write at wcnt==K*K-1, go to LOAD_X with xcnt=0.
REQ-025 LOAD_X SHALL write each transfer to X[xcnt]; after the write at xcnt==R*C-1, go to DONE.
REQ-026 Write counters SHALL clear to 0 on every entry into IDLE.
REQ-027 DONE SHALL assert inputs_loaded=1 (0 in all other states); on compute_finished=1, go to IDLE next cycle.
REQ-028 compute_finished SHALL be ignored outside DONE.
REQ-029 Memory address mux: in LOAD_W/LOAD_X/IDLE the write counter drives the address; in DONE X_read_addr/W_read_addr drive it; X_data/W_data are valid the cycle after the address is presented.
REQ-030 A batch with new_W=0 SHALL reuse the previous W contents and K unchanged.
REQ-031 TUSER on non-first words SHALL be ignored.
REQ-032 Read addresses outside the loaded range SHALL return unspecified data but never corrupt state.

Reset
REQ-033 On reset: state=IDLE, wcnt=0, xcnt=0, K=0, inputs_loaded=0; AXIS_TREADY=1 once reset deasserts.
REQ-034 Memory contents SHALL NOT be cleared by reset.
REQ-035 Reset asserted mid-load SHALL abort the load immediately; the next transfer is treated as a first word.

Verification
REQ-036 R=3,C=3: TUSER={K=2,new_W=1}, 13 words 1..13, TVALID always 1 -> W=[1,2,3,4], X=[5..13], inputs_loaded rises the cycle after word 13, TREADY falls at the same time.
REQ-037 After REQ-036, compute_finished=1 for 1 cycle, then 9 words 20..28 with new_W=0 -> X=[20..28], W still [1,2,3,4], K=2.
REQ-038 TVALID toggling 1/0 every cycle during the REQ-036 load -> identical memory contents, load takes 26 cycles.
REQ-039 In DONE, present X_read_addr=4 -> X_data=9 one cycle later; compute_finished pulsed in LOAD_X -> no effect.
REQ-040 reset pulsed after word 6 of REQ-036 -> inputs_loaded=0, K=0; a fresh K=1 batch (1 W word + 9 X words) loads correctly.
